// File: rtl/instr_loader_pkg.sv
// Shared types and frame sizing for the instruction loader.
// INSTR_LOADER_PARITY_EN adds one trailing even-parity bit to every serial frame.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  localparam int unsigned INSTR_W_DEFAULT = 9;

`ifdef INSTR_LOADER_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  localparam int unsigned FRAME_W = INSTR_W_DEFAULT + PARITY_BITS;

  function automatic int unsigned frame_len(input int unsigned instr_w);
    return instr_w + PARITY_BITS;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Pin-side serial input and cpu-side instruction bus of the loader.
// The loader is the master; the cpu/pin side is the slave.
interface instr_loader_if
  import instr_loader_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  parameter int unsigned DEPTH   = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               SER_IN;
  logic               SER_VALID;
  logic               START;
  logic               CLEAR;
  logic [INSTR_W-1:0] INSTRUCTION;
  logic               write_en;
  logic               BUSY;
  logic [CNT_W-1:0]   COUNT;
  logic               FULL;
  logic               ERR;

  modport master (
    input  SER_IN, SER_VALID, START, CLEAR,
    output INSTRUCTION, write_en, BUSY, COUNT, FULL, ERR
  );

  modport slave (
    output SER_IN, SER_VALID, START, CLEAR,
    input  INSTRUCTION, write_en, BUSY, COUNT, FULL, ERR
  );
endinterface

// File: rtl/instr_deser.sv
// MSB-first serial-to-word deserialiser; word_done/word_bad pulse on the final frame bit.
// INSTR_LOADER_PARITY_EN: frame carries a trailing even-parity bit checked here.
module instr_deser
  import instr_loader_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ser_in,
  input  logic               ser_valid,
  input  logic               enable,
  output logic [INSTR_W-1:0] word,
  output logic               word_done,
  output logic               word_bad
);
  localparam int unsigned FW = frame_len(INSTR_W);
  localparam int unsigned BW = $clog2(FW + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);

  logic [FW-2:0] shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] frame;

  // Word is presented combinationally so the buffer write lands on the capturing edge.
  always_comb begin
    frame     = {shift_q, ser_in};
    word_done = enable && ser_valid && (bit_cnt_q == LAST_BIT);
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (enable && ser_valid) begin
      shift_d   = frame[FW-2:0];
      bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
    end
  end

`ifdef INSTR_LOADER_PARITY_EN
  assign word     = frame[FW-1:1];
  assign word_bad = word_done && (^frame);
`else
  assign word     = frame;
  assign word_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Buffers serially loaded program words and replays them to the cpu on START.
// Optional INSTR_LOADER_PARITY_EN enables per-frame even parity (see instr_deser).
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned INSTR_W     = INSTR_W_DEFAULT,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic           CLK,
  input  logic           RESET,
  instr_loader_if.master bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
  logic               mem_we;
  logic [INSTR_W-1:0] word;
  logic               word_done, word_bad;

  instr_deser #(.INSTR_W(INSTR_W)) u_deser (
    .clk       (CLK),
    .rst_n     (RESET),
    .ser_in    (bus.SER_IN),
    .ser_valid (bus.SER_VALID),
    .enable    (state_q != RUN),
    .word      (word),
    .word_done (word_done),
    .word_bad  (word_bad)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_cnt_d = rd_cnt_q;
    count_d  = count_q;
    step_d   = step_q;
    instr_d  = instr_q;
    busy_d   = busy_q;
    err_d    = err_q;
    we_d     = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.SER_VALID) begin
          state_d = LOAD;
        end else if (bus.START && (count_q != '0)) begin
          // The START edge itself issues word 0; rd_cnt then tracks words issued.
          state_d  = RUN;
          busy_d   = 1'b1;
          instr_d  = mem_q[0];
          we_d     = 1'b1;
          rd_cnt_d = CNT_W'(1);
          step_d   = '0;
        end else if (bus.CLEAR) begin
          count_d  = '0;
          err_d    = 1'b0;
          wr_ptr_d = '0;
        end
      end
      LOAD: begin
        if (word_done) begin
          state_d = IDLE;
          if (word_bad || full_q) begin
            err_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (rd_cnt_q == count_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (step_q == STEP_LAST) begin
          instr_d  = mem_q[rd_cnt_q[PTR_W-1:0]];
          we_d     = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
          step_d   = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    full_d = (count_d == CNT_FULL);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_cnt_q <= '0;
      count_q  <= '0;
      step_q   <= '0;
      instr_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_cnt_q <= rd_cnt_d;
      count_q  <= count_d;
      step_q   <= step_d;
      instr_q  <= instr_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && mem_we) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  assign bus.INSTRUCTION = instr_q;
  assign bus.write_en    = we_q;
  assign bus.BUSY        = busy_q;
  assign bus.COUNT       = count_q;
  assign bus.FULL        = full_q;
  assign bus.ERR         = err_q;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Producer end of the CPU instruction interface. It takes program words bit-serially from a single input pin and holds up to DEPTH words in a local buffer. On START it replays the buffer to the CPU as 9-bit INSTRUCTION words, each qualified by a one-cycle write_en pulse. It sits between the chip input pins and the cpu block's INSTRUCTION/write_en inputs.

Parameters:
INSTR_W, 9, instruction word width; must match the cpu INSTRUCTION width.
DEPTH, 8, program buffer entries; power of two, 2..16.
STEP_CYCLES, 1, cycles between consecutive write_en pulses in RUN; 1 means back-to-back; must be >=1.

Ports:
CLK  input  1  clock; all logic on rising edge.
RESET  input  1  synchronous, active-low reset; RESET==0 at a rising CLK edge resets the block.
SER_IN  input  1  serial program data, MSB first.
SER_VALID  input  1  SER_IN is sampled on every edge where this is high.
START  input  1  single-cycle request to replay the buffer.
CLEAR  input  1  empties the buffer and clears ERR; honoured in IDLE only.
INSTRUCTION  output  INSTR_W  word presented to the cpu (registered).
write_en  output  1  one-cycle strobe qualifying INSTRUCTION (registered).
BUSY  output  1  high while in RUN.
COUNT  output  $clog2(DEPTH)+1  number of stored words.
FULL  output  1  COUNT==DEPTH.
ERR  output  1  sticky: a word was dropped.

Behaviour:
- Reset values: INSTRUCTION=0, write_en=0, BUSY=0, COUNT=0, FULL=0, ERR=0.
- Reset also clears the write pointer, read pointer, bit counter, shift register and step counter, and sets state to IDLE.
- Buffer contents are not cleared by reset and are don't-care afterwards.
- Reset mid-LOAD discards the partial word. Reset mid-RUN stops issue immediately, with write_en=0 in the next cycle.
- States: IDLE, LOAD, RUN.
- IDLE:
  - SER_VALID=1: capture SER_IN as bit 1, go to LOAD.
  - Else START=1 and COUNT>0: go to RUN.
  - Else CLEAR=1: COUNT<=0, ERR<=0, write pointer <=0.
  - START with COUNT==0 is ignored.
  - Priority: SER_VALID > START > CLEAR.
- LOAD:
  - Each edge with SER_VALID=1 shifts SER_IN into the LSB and increments the bit counter.
  - SER_VALID=0 holds state. There is no timeout.
  - On the edge capturing the final frame bit (bit 9), the assembled word is written to buf[wr_ptr]. Then wr_ptr+1 (wraps mod DEPTH), COUNT+1, return to IDLE.
  - If FULL when the word completes: the word is dropped, COUNT is unchanged, ERR<=1.
  - START and CLEAR are ignored in LOAD.
- RUN:
  - On the edge that accepts START: rd_ptr<=0, step counter<=0, and the first issue happens on that same edge. INSTRUCTION<=buf[0] and write_en<=1, so they are visible one cycle after START is sampled.
  - write_en is high for exactly one cycle per word, followed by STEP_CYCLES-1 low cycles, then the next word.
  - INSTRUCTION holds the last issued word between pulses and after RUN ends.
  - Words are issued in index order 0..COUNT-1, where index 0 is the oldest word.
  - After word COUNT-1 is issued: state<=IDLE and BUSY<=0 on the following edge. The buffer and COUNT are kept, so a new START replays the same program.
  - SER_VALID, START and CLEAR are ignored in RUN. Serial bits presented during RUN are lost.
- Width rules:
  - COUNT saturates at DEPTH.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - The bit counter is sized to the frame length.

Optional Feature:
Macro INSTR_LOADER_PARITY_EN.
- Defined: the frame is INSTR_W+1 bits, with an even-parity bit last. On a parity mismatch the word is dropped, ERR<=1, and the state returns to IDLE.
- Undefined: the frame is INSTR_W bits with no parity, and ERR is set only by overflow.

Decomposition:
- Package instr_loader_pkg holds:
  - the state enum {IDLE, LOAD, RUN};
  - INSTR_W_DEFAULT=9;
  - a FRAME_W localparam derived from INSTR_W and the parity macro.
- Sub-module instr_deser holds the shift register, bit counter and optional parity check. It outputs a word and a one-cycle word_done/word_bad pulse. The top level owns the buffer, pointers, FSM and output registers.

Test Plan:
1. Reset release, then serial-load 9'h1A5 and 9'h0F3 (MSB first), then START -> COUNT=2. Cycle after START: INSTRUCTION=0x1A5, write_en=1. Next cycle: 0x0F3, write_en=1. Next: write_en=0, BUSY=0.
2. STEP_CYCLES=3, three words loaded, START -> write_en pulses at cycles +1, +4 and +7, low in between; INSTRUCTION holds each word for 3 cycles.
3. DEPTH=8: load 9 words -> after the 8th, FULL=1 and COUNT=8. The 9th is dropped with ERR=1. START replays only the first 8.
4. Load 4 of 9 bits, assert RESET=0 for one cycle, then load 9'h001 -> COUNT=1, INSTRUCTION after START =0x001. Also: RESET mid-RUN gives write_en=0 on the next cycle.
5. START with COUNT=0 -> no write_en ever, BUSY stays 0. CLEAR in IDLE after an overflow -> COUNT=0, ERR=0. SER_VALID and START in the same IDLE cycle -> LOAD entered, no issue.
6. With INSTR_LOADER_PARITY_EN: 9'h1A5 with a correct parity bit is stored; the same word with a flipped parity bit gives COUNT unchanged and ERR=1.
